// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX stage and the
// multi-cycle RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  modport master (
    output start, funct3, rs1, rs2, kill,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, funct3, rs1, rs2, kill,
    output busy, done, result, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Multiplies take one working cycle; divides use a restoring radix-2 loop
// producing one quotient bit per cycle. Divide-by-zero and signed overflow
// are resolved directly from IDLE without entering the divide loop.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave io_bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_busy;
  logic [XLEN-1:0]  r_result;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_op1;
  logic [XLEN-1:0]  r_op2;
  logic [XLEN-1:0]  r_dvd;
  logic [XLEN-1:0]  r_dvs;
  logic [XLEN-1:0]  r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_negQ;
  logic             r_negR;

  // Request decode in IDLE (funct3[0]=0 selects the signed divide flavours).
  logic             w_accept;
  logic             w_isDivOp;
  logic             w_isRemOp;
  logic             w_opSigned;
  logic             w_divZero;
  logic             w_overflow;
  logic [XLEN-1:0]  w_rs1Mag;
  logic [XLEN-1:0]  w_rs2Mag;

  // Multiply datapath.
  logic             w_aSign;
  logic             w_bSign;
  logic signed [2*XLEN-1:0] w_mulA;
  logic signed [2*XLEN-1:0] w_mulB;
  logic signed [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]  w_mulRes;

  // Divide step datapath.
  logic [XLEN:0]    w_remShift;
  logic [XLEN:0]    w_diff;
  logic             w_qBit;
  logic [XLEN-1:0]  w_remNext;
  logic [XLEN-1:0]  w_dvdNext;
  logic [XLEN-1:0]  w_quotFix;
  logic [XLEN-1:0]  w_remFix;
  logic [XLEN-1:0]  w_divRes;
  logic             w_done;

  assign w_accept   = (r_state == S_IDLE) & io_bus.start & ~io_bus.kill;
  assign w_isDivOp  = io_bus.funct3[2];
  assign w_isRemOp  = io_bus.funct3[1];
  assign w_opSigned = ~io_bus.funct3[0];
  assign w_divZero  = (io_bus.rs2 == '0);
  assign w_overflow = w_opSigned & (io_bus.rs1 == MIN_NEG) & (io_bus.rs2 == ALL_ONES);
  assign w_rs1Mag   = (w_opSigned & io_bus.rs1[XLEN-1]) ? -io_bus.rs1 : io_bus.rs1;
  assign w_rs2Mag   = (w_opSigned & io_bus.rs2[XLEN-1]) ? -io_bus.rs2 : io_bus.rs2;

  // The 33x33 signed product is formed on operands already widened to 64 bits;
  // the low 64 bits of that product are exact, which is all MUL/MULH* need.
  assign w_aSign  = (r_funct3[1] ^ r_funct3[0]) & r_op1[XLEN-1];
  assign w_bSign  = (r_funct3[1:0] == 2'b01) & r_op2[XLEN-1];
  assign w_mulA   = {{XLEN{w_aSign}}, r_op1};
  assign w_mulB   = {{XLEN{w_bSign}}, r_op2};
  assign w_prod   = w_mulA * w_mulB;
  assign w_mulRes = (r_funct3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // The subtraction is one bit wider than the operands; its top bit is the
  // borrow, so "remainder >= divisor" never suffers from wrap-around.
  assign w_remShift = {r_rem, r_dvd[XLEN-1]};
  assign w_diff     = w_remShift - {1'b0, r_dvs};
  assign w_qBit     = ~w_diff[XLEN];
  assign w_remNext  = w_qBit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];
  assign w_dvdNext  = {r_dvd[XLEN-2:0], w_qBit};
  assign w_quotFix  = r_negQ ? -w_dvdNext : w_dvdNext;
  assign w_remFix   = r_negR ? -w_remNext : w_remNext;
  assign w_divRes   = r_funct3[1] ? w_remFix : w_quotFix;

  assign w_done        = (r_state == S_DONE);
  assign io_bus.done   = w_done;
  assign io_bus.stall  = io_bus.start & ~w_done;
  assign io_bus.busy   = r_busy;
  assign io_bus.result = r_result;

  // State register; reset drops any operation in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; kill overrides everything and returns to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_isDivOp) begin
            w_nextState = S_MUL;
          end else if (w_divZero || w_overflow) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_DIV;
          end
        end
      end
      S_MUL:   w_nextState = S_DONE;
      S_DIV:   if (r_cnt == '0) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    if (io_bus.kill) begin
      w_nextState = S_IDLE;
    end
  end

  // Operand latching, divide iteration and result write (only when entering DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_result <= '0;
      r_funct3 <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
    end else begin
      r_busy <= (w_nextState == S_MUL) || (w_nextState == S_DIV);
      if (!io_bus.kill) begin
        case (r_state)
          S_IDLE: begin
            if (io_bus.start) begin
              r_funct3 <= io_bus.funct3;
              r_op1    <= io_bus.rs1;
              r_op2    <= io_bus.rs2;
              r_dvd    <= w_rs1Mag;
              r_dvs    <= w_rs2Mag;
              r_rem    <= '0;
              r_cnt    <= CW'(XLEN - 1);
              r_negQ   <= w_opSigned & (io_bus.rs1[XLEN-1] ^ io_bus.rs2[XLEN-1]);
              r_negR   <= w_opSigned & io_bus.rs1[XLEN-1];
              if (w_isDivOp && w_divZero) begin
                r_result <= w_isRemOp ? io_bus.rs1 : ALL_ONES;
              end else if (w_isDivOp && w_overflow) begin
                r_result <= w_isRemOp ? '0 : MIN_NEG;
              end
            end
          end
          S_MUL: begin
            r_result <= w_mulRes;
          end
          S_DIV: begin
            r_rem <= w_remNext;
            r_dvd <= w_dvdNext;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
              r_result <= w_divRes;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed stimulus for muldiv_unit with a
// queue-based scoreboard fed by a plain-arithmetic reference model.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    logic [2:0]  op;
  } exp_t;

  logic clk;
  logic rst;
  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stallCnt = 0;
  int          busyCnt = 0;
  logic [31:0] lastExp = '0;
  exp_t        scoreQ[$];

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index; a value read between edges names the current cycle.
  always @(posedge clk) cyc++;

  // Reference result computed from the instruction semantics with 64-bit arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accepting cycle to the done pulse.
  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic driveOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.kill   = 1'b0;
    bus.start  = 1'b1;
  endtask

  // Drive an operation in the current cycle and record what it must produce.
  task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    driveOp(f3, a, b);
    e.res = refResult(f3, a, b);
    e.lat = refLatency(f3, a, b);
    e.t0  = cyc;
    e.op  = f3;
    scoreQ.push_back(e);
    lastExp = e.res;
  endtask

  task automatic waitDone();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) begin
      errors++;
      checks++;
      $display("[TB] FAIL done_timeout: no done after %0d cycles, required within 33", n);
      finishRun();
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    startOp(f3, a, b);
    waitDone();
  endtask

  task automatic applyDirected(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] want);
    applyStimulus(f3, a, b);
    checkOutput(name, bus.result, want);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks result, latency,
  // stall-cycle count and busy-cycle count for that operation.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst || bus.kill) begin
      stallCnt = 0;
      busyCnt  = 0;
    end else begin
      if (bus.stall) stallCnt++;
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        if (scoreQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: done seen at cycle %0d, required none", cyc);
        end else begin
          e = scoreQ.pop_front();
          checkOutput($sformatf("result_op%0d", e.op), bus.result, e.res);
          checkOutput($sformatf("latency_op%0d", e.op), 32'(cyc - e.t0), 32'(e.lat));
          checkOutput($sformatf("stall_cycles_op%0d", e.op), 32'(stallCnt), 32'(e.lat));
          checkOutput($sformatf("busy_cycles_op%0d", e.op), 32'(busyCnt), 32'(e.lat - 1));
        end
        stallCnt = 0;
        busyCnt  = 0;
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finishRun();
  end

  // Main stimulus sequence.
  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = '0;
    bus.rs1    = '0;
    bus.rs2    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    applyDirected("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    applyDirected("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    applyDirected("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyDirected("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyDirected("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    applyDirected("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    applyDirected("divu_by0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF);
    applyDirected("remu_by0", 3'b111, 32'd100, 32'd0, 32'd100);
    applyDirected("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    applyDirected("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    applyDirected("b2b_divu", 3'b101, 32'd9, 32'd4, 32'd2);
    applyDirected("b2b_remu", 3'b111, 32'd9, 32'd4, 32'd1);

    // Kill a divide ten cycles in, then start a MULHU right after.
    @(negedge clk);
    driveOp(3'b100, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    checkOutput("kill_busy", 32'(bus.busy), 32'd0);
    checkOutput("kill_done", 32'(bus.done), 32'd0);
    checkOutput("kill_result_held", bus.result, lastExp);
    startOp(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    waitDone();

    // Asynchronous reset five cycles into a divide.
    @(negedge clk);
    startOp(3'b100, 32'd5000, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("async_rst_done", 32'(bus.done), 32'd0);
    checkOutput("async_rst_result", bus.result, 32'd0);
    scoreQ.delete(scoreQ.size() - 1);
    lastExp = '0;
    @(negedge clk);
    bus.start = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_rst_done", 32'(bus.done), 32'd0);
    applyStimulus(3'b000, 32'd12345, 32'd678);

    // Randomized mix with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
    end

    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'd0);
    finishRun();
  end

endmodule
